// File: rtl/regfile_wb_decode_pkg.sv
// Shared MIPS datapath definitions: fixed register indices, writeback-select
// encodings and the register-file sequencer state type.
package mips_defs;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  localparam logic [1:0] WB_RD = 2'b00;
  localparam logic [1:0] WB_RT = 2'b01;
  localparam logic [1:0] WB_RA = 2'b10;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  // Destination register chosen by the writeback select (JAL links into $ra).
  function automatic logic [4:0] wb_dest(input logic [1:0] sel,
                                         input logic [4:0] rd,
                                         input logic [4:0] rt);
    case (sel)
      WB_RD:   return rd;
      WB_RT:   return rt;
      WB_RA:   return REG_RA;
      default: return REG_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/decoder5to32.sv
// Write-side address decoder: enable + register index -> one-hot write enables.
// Register 0 is hard-wired, so its enable bit is never asserted.
module decoder5to32 #(
  parameter int ADDR_W = 5
) (
  input  logic                     enable,
  input  logic [ADDR_W-1:0]        addr,
  output logic [(2**ADDR_W)-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (enable) onehot[addr] = 1'b1;
    onehot[0] = 1'b0;
  end

endmodule

// File: rtl/regfile_wb_decode.sv
// MIPS register file write side: one-hot decoded writes, two combinational read
// ports with optional write-through, and a post-reset clear sequencer.
//
//  state | meaning
//  CLEAR | zeroing reg[clr_idx] one per cycle; reads return 0, writes dropped
//  RUN   | normal operation; decoded writes commit on the rising edge
module regfile_wb_decode
  import mips_defs::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              ready,
  output logic              wr_dropped
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

  rf_state_e         state;
  logic [ADDR_W-1:0] clr_idx;
  logic [NREG-1:0]   wr_sel;
  logic [WIDTH-1:0]  regs [NREG];
  logic              byp_a;
  logic              byp_b;

  decoder5to32 #(.ADDR_W(ADDR_W)) u_dec (
    .enable (wr_en & ready),
    .addr   (wr_addr),
    .onehot (wr_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      clr_idx    <= '0;
      ready      <= 1'b0;
      wr_dropped <= 1'b0;
    end else begin
      wr_dropped <= wr_en & ~ready;
      case (state)
        CLEAR: begin
          // clr_idx parks on the last index so it never wraps back over live data
          if (clr_idx == LAST_IDX) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        RUN:     state <= RUN;
        default: state <= CLEAR;
      endcase
    end
  end

  // Contents are not reset; the CLEAR sequence zeroes them instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        regs[clr_idx] <= '0;
      end else begin
        for (int i = 0; i < NREG; i++) begin
          if (wr_sel[i]) regs[i] <= wr_data;
        end
      end
    end
  end

  assign byp_a = BYPASS && wr_en && ready && (wr_addr == rd_addr_a);
  assign byp_b = BYPASS && wr_en && ready && (wr_addr == rd_addr_b);

  assign rd_data_a = (!ready || rd_addr_a == ZERO_IDX) ? '0 :
                     byp_a ? wr_data : regs[rd_addr_a];
  assign rd_data_b = (!ready || rd_addr_b == ZERO_IDX) ? '0 :
                     byp_b ? wr_data : regs[rd_addr_b];

endmodule

// File: tb/tb_regfile_wb_decode.sv
// Bench for regfile_wb_decode: a write-through and a non-bypass instance share
// stimulus and are compared against a cycle-level behavioural register model.
module tb_regfile_wb_decode;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rda1, rdb1, rda0, rdb0;
  logic        rdy1, rdy0, drop1, drop0;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model: register contents, cycles since reset, ready flag
  logic [31:0] m_regs [32];
  int          m_cnt;
  bit          m_ready;
  bit          m_drop;

  regfile_wb_decode #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rda1), .rd_data_b(rdb1),
    .ready(rdy1), .wr_dropped(drop1)
  );

  regfile_wb_decode #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nob (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rda0), .rd_data_b(rdb0),
    .ready(rdy0), .wr_dropped(drop0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, updating the model from the inputs that the edge samples.
  task automatic tick();
    if (reset) begin
      m_cnt = 0; m_ready = 0; m_drop = 0;
    end else begin
      m_drop = wr_en && !m_ready;
      if (!m_ready) begin
        m_regs[m_cnt] = 32'h0;
        m_cnt++;
        if (m_cnt == 32) m_ready = 1;
      end else if (wr_en && wr_addr != 5'd0) begin
        m_regs[wr_addr] = wr_data;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (!m_ready || a == 5'd0) return 32'h0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  task automatic test_reset();
    reset = 1; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr_a = 5; rd_addr_b = 31;
    tick(); tick();
    reset = 0;
    #1;
    n_cmp++;
    if (rdy1 !== 1'b0 || rdy0 !== 1'b0 || drop1 !== 1'b0) begin
      n_bad++; $display("FAIL reset_state: ready=%b/%b dropped=%b, need 0", rdy1, rdy0, drop1);
    end
    for (int k = 1; k <= 32; k++) begin
      n_cmp++;
      if (rda1 !== 32'h0 || rdb1 !== 32'h0 || rda0 !== 32'h0 || rdb0 !== 32'h0) begin
        n_bad++; $display("FAIL clear_reads k=%0d: got %h %h %h %h, need 0", k, rda1, rdb1, rda0, rdb0);
      end
      tick();
      n_cmp++;
      if (rdy1 !== (k == 32) || rdy0 !== (k == 32)) begin
        n_bad++; $display("FAIL ready_timing edge %0d: got %b/%b need %b", k, rdy1, rdy0, k == 32);
      end
    end
  endtask

  task automatic test_write();
    wr_en = 1; wr_addr = 10; wr_data = 32'hDEADBEEF; rd_addr_a = 10; rd_addr_b = 0;
    #1;
    n_cmp++;
    if (rda1 !== 32'hDEADBEEF || rda0 !== 32'h0) begin
      n_bad++; $display("FAIL write_same_cycle: byp=%h nob=%h need DEADBEEF/0", rda1, rda0);
    end
    tick();
    wr_en = 0;
    #1;
    n_cmp++;
    if (rda1 !== 32'hDEADBEEF || rda0 !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL write_reg10: got %h/%h need DEADBEEF", rda1, rda0);
    end
    n_cmp++;
    if (rdb1 !== 32'h0 || rdb0 !== 32'h0) begin
      n_bad++; $display("FAIL read_reg0: got %h/%h need 0", rdb1, rdb0);
    end
  endtask

  task automatic test_reg0();
    wr_en = 1; wr_addr = 0; wr_data = 32'h12345678; rd_addr_a = 0; rd_addr_b = 0;
    #1;
    n_cmp++;
    if (rda1 !== 32'h0 || rdb1 !== 32'h0) begin
      n_bad++; $display("FAIL reg0_bypass: got %h/%h need 0", rda1, rdb1);
    end
    tick();
    wr_en = 0;
    #1;
    n_cmp++;
    if (rda1 !== 32'h0 || rda0 !== 32'h0) begin
      n_bad++; $display("FAIL reg0_write: got %h/%h need 0", rda1, rda0);
    end
    n_cmp++;
    if (drop1 !== 1'b0 || drop0 !== 1'b0) begin
      n_bad++; $display("FAIL reg0_dropped: got %b/%b need 0", drop1, drop0);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1; wr_addr = 31; wr_data = 32'hA5A50031;
    tick();
    wr_data = 32'h00400004; rd_addr_a = 31; rd_addr_b = 31;
    #1;
    n_cmp++;
    if (rda1 !== 32'h00400004 || rdb1 !== 32'h00400004) begin
      n_bad++; $display("FAIL bypass_on: got %h/%h need 00400004", rda1, rdb1);
    end
    n_cmp++;
    if (rda0 !== 32'hA5A50031 || rdb0 !== 32'hA5A50031) begin
      n_bad++; $display("FAIL bypass_off_old: got %h/%h need A5A50031", rda0, rdb0);
    end
    tick();
    wr_en = 0;
    #1;
    n_cmp++;
    if (rda0 !== 32'h00400004 || rdb0 !== 32'h00400004 || rda1 !== 32'h00400004) begin
      n_bad++; $display("FAIL bypass_after_edge: got %h/%h/%h need 00400004", rda0, rdb0, rda1);
    end
  endtask

  task automatic test_drop_in_clear();
    int budget;
    reset = 1; wr_en = 0;
    tick();
    reset = 0;
    for (int k = 1; k < 10; k++) tick();
    wr_en = 1; wr_addr = 21; wr_data = 32'h0000FFFF;
    tick();
    wr_en = 0;
    n_cmp++;
    if (drop1 !== 1'b1 || drop0 !== 1'b1) begin
      n_bad++; $display("FAIL drop_pulse: got %b/%b need 1", drop1, drop0);
    end
    tick();
    n_cmp++;
    if (drop1 !== 1'b0 || drop0 !== 1'b0) begin
      n_bad++; $display("FAIL drop_one_cycle: got %b/%b need 0", drop1, drop0);
    end
    budget = 0;
    while (rdy1 !== 1'b1 && budget < 40) begin
      tick(); budget++;
    end
    n_cmp++;
    if (rdy1 !== 1'b1 || rdy0 !== 1'b1) begin
      n_bad++; $display("FAIL drop_ready_timeout: ready=%b/%b after %0d cycles", rdy1, rdy0, budget);
    end
    rd_addr_a = 21; rd_addr_b = 21;
    #1;
    n_cmp++;
    if (rda1 !== 32'h0 || rdb0 !== 32'h0) begin
      n_bad++; $display("FAIL dropped_not_written: got %h/%h need 0", rda1, rdb0);
    end
  endtask

  task automatic test_fill_reset();
    for (int i = 1; i < 32; i++) begin
      wr_en = 1; wr_addr = 5'(i); wr_data = 32'(i);
      tick();
    end
    wr_en = 0;
    for (int i = 1; i < 32; i++) begin
      rd_addr_a = 5'(i); rd_addr_b = 5'(32 - i);
      #1;
      n_cmp++;
      if (rda1 !== 32'(i) || rdb0 !== 32'(32 - i)) begin
        n_bad++; $display("FAIL fill_reg%0d: got %h/%h need %0d/%0d", i, rda1, rdb0, i, 32 - i);
      end
    end
    reset = 1;
    tick();
    n_cmp++;
    if (rdy1 !== 1'b0 || rdy0 !== 1'b0) begin
      n_bad++; $display("FAIL reset_run_ready: got %b/%b need 0", rdy1, rdy0);
    end
    reset = 0;
    for (int k = 0; k < 32; k++) tick();
    n_cmp++;
    if (rdy1 !== 1'b1 || rdy0 !== 1'b1) begin
      n_bad++; $display("FAIL reclear_ready: got %b/%b need 1", rdy1, rdy0);
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i); rd_addr_b = 5'(i);
      #1;
      n_cmp++;
      if (rda1 !== 32'h0 || rdb1 !== 32'h0 || rda0 !== 32'h0 || rdb0 !== 32'h0) begin
        n_bad++; $display("FAIL reclear_reg%0d: got %h %h %h %h need 0", i, rda1, rdb1, rda0, rdb0);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ea1, eb1, ea0, eb0;
    for (int c = 0; c < 400; c++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      #1;
      ea1 = exp_rd(rd_addr_a, 1); eb1 = exp_rd(rd_addr_b, 1);
      ea0 = exp_rd(rd_addr_a, 0); eb0 = exp_rd(rd_addr_b, 0);
      n_cmp++;
      if (rda1 !== ea1 || rdb1 !== eb1) begin
        n_bad++; $display("FAIL rand_byp c=%0d a=%0d b=%0d: got %h/%h need %h/%h", c, rd_addr_a, rd_addr_b, rda1, rdb1, ea1, eb1);
      end
      n_cmp++;
      if (rda0 !== ea0 || rdb0 !== eb0) begin
        n_bad++; $display("FAIL rand_nob c=%0d a=%0d b=%0d: got %h/%h need %h/%h", c, rd_addr_a, rd_addr_b, rda0, rdb0, ea0, eb0);
      end
      tick();
      n_cmp++;
      if (drop1 !== m_drop || rdy1 !== m_ready) begin
        n_bad++; $display("FAIL rand_status c=%0d: dropped=%b ready=%b need %b/%b", c, drop1, rdy1, m_drop, m_ready);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 0; m_ready = 0; m_drop = 0;
    test_reset();
    test_write();
    test_reg0();
    test_bypass();
    test_drop_in_clear();
    test_fill_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
